// File: rtl/multdiv_unit_pkg.sv
// multdiv_unit_pkg: shared encodings and sizing for the multiply/divide unit
package multdiv_unit_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  typedef enum logic {OP_MULT = 1'b0, OP_DIV = 1'b1} op_t;
  localparam logic [31:0] RSTATUS_MUL_DEF = 32'd4;
  localparam logic [31:0] RSTATUS_DIV_DEF = 32'd5;
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/multdiv_unit_div_step.sv
// multdiv_unit_div_step: one restoring-division iteration on unsigned magnitudes
module multdiv_unit_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] sh, diff;
  // rem_i < div_i <= 2^(WIDTH-1), so sh never reaches bit WIDTH and diff[WIDTH] is a clean borrow
  always_comb begin
    sh = {rem_i, bit_i};
    diff = sh - {1'b0, div_i};
    q_o = ~diff[WIDTH];
    rem_o = q_o ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  end
endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed Booth multiply / restoring divide, fixed WIDTH+1 cycle latency
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] RSTATUS_MUL = RSTATUS_MUL_DEF,
  parameter logic [31:0] RSTATUS_DIV = RSTATUS_DIV_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic [31:0]      rstatus_value,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CW = cnt_width(WIDTH);
  state_t state_q, state_d;
  op_t op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d, m_q, m_d, res_q, res_d;
  logic qm1_q, qm1_d, neg_q, neg_d, bz_q, bz_d, exc_q, exc_d, rdy_q, rdy_d, busy_q, busy_d;
  logic [31:0] rst_q, rst_d;
  logic start, a_neg, b_neg, mul_exc, div_exc, qb;
  logic [WIDTH:0] m_ext, sum;
  logic [WIDTH-1:0] rem_n, quot;
  logic [WIDTH:0] top;
  multdiv_unit_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i(acc_q[WIDTH-1:0]),
    .div_i(m_q),
    .bit_i(q_q[WIDTH-1]),
    .rem_o(rem_n),
    .q_o  (qb)
  );
  always_comb begin
    start = ctrl_MULT | ctrl_DIV;
    a_neg = data_operandA[WIDTH-1];
    b_neg = data_operandB[WIDTH-1];
    m_ext = {m_q[WIDTH-1], m_q};
    // accumulator carries one guard bit so subtracting the most negative multiplicand cannot wrap
    sum = (q_q[0] & ~qm1_q) ? acc_q - m_ext : (~q_q[0] & qm1_q) ? acc_q + m_ext : acc_q;
    top = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    mul_exc = ~(&top | ~|top);
    quot = neg_q ? -q_q : q_q;
    div_exc = bz_q | (~neg_q & q_q[WIDTH-1]);
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    q_d = q_q;
    qm1_d = qm1_q;
    m_d = m_q;
    neg_d = neg_q;
    bz_d = bz_q;
    res_d = res_q;
    exc_d = exc_q;
    rst_d = rst_q;
    rdy_d = 1'b0;
    busy_d = busy_q;
    if (start) begin
      state_d = RUN;
      op_d = ctrl_MULT ? OP_MULT : OP_DIV;
      cnt_d = '0;
      acc_d = '0;
      qm1_d = 1'b0;
      q_d = ctrl_MULT ? data_operandB : (a_neg ? -data_operandA : data_operandA);
      m_d = ctrl_MULT ? data_operandA : (b_neg ? -data_operandB : data_operandB);
      neg_d = a_neg ^ b_neg;
      bz_d = ~|data_operandB;
      busy_d = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          acc_d = (op_q == OP_MULT) ? {sum[WIDTH], sum[WIDTH:1]} : {1'b0, rem_n};
          q_d = (op_q == OP_MULT) ? {sum[0], q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], qb};
          qm1_d = q_q[0];
          cnt_d = cnt_q + 1'b1;
          state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : RUN;
        end
        DONE: begin
          res_d = (op_q == OP_MULT) ? q_q : (bz_q ? '0 : quot);
          exc_d = (op_q == OP_MULT) ? mul_exc : div_exc;
          rst_d = exc_d ? ((op_q == OP_MULT) ? RSTATUS_MUL : RSTATUS_DIV) : 32'd0;
          rdy_d = 1'b1;
          state_d = IDLE;
        end
        default: busy_d = 1'b0;
      endcase
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q <= OP_MULT;
      cnt_q <= '0;
      acc_q <= '0;
      q_q <= '0;
      qm1_q <= 1'b0;
      m_q <= '0;
      neg_q <= 1'b0;
      bz_q <= 1'b0;
      res_q <= '0;
      exc_q <= 1'b0;
      rst_q <= '0;
      rdy_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      q_q <= q_d;
      qm1_q <= qm1_d;
      m_q <= m_d;
      neg_q <= neg_d;
      bz_q <= bz_d;
      res_q <= res_d;
      exc_q <= exc_d;
      rst_q <= rst_d;
      rdy_q <= rdy_d;
      busy_q <= busy_d;
    end
  end
  assign data_result = res_q;
  assign data_exception = exc_q;
  assign rstatus_value = rst_q;
  assign data_resultRDY = rdy_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: scoreboard bench; stimulus pushes expectations, a negedge monitor pops on data_resultRDY
module tb_multdiv_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic [31:0] data_result, rstatus_value;
  logic data_exception, data_resultRDY, busy;
  typedef struct {
    string nm;
    logic [31:0] r;
    logic e;
    logic [31:0] s;
    int t;
  } exp_t;
  exp_t sb[$];
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  multdiv_unit dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .rstatus_value(rstatus_value), .data_resultRDY(data_resultRDY), .busy(busy)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clock) begin
    if (reset && data_resultRDY) begin
      if (sb.size() == 0) chk("spurious_rdy", 32'd1, 32'd0);
      else begin
        exp_t x;
        x = sb.pop_front();
        chk({x.nm, "_result"}, data_result, x.r);
        chk({x.nm, "_exception"}, {31'd0, data_exception}, {31'd0, x.e});
        chk({x.nm, "_rstatus"}, rstatus_value, x.s);
        chk({x.nm, "_latency"}, cyc, x.t);
      end
    end
  end
  // caller sits on a negedge; start is sampled at the following posedge
  task automatic issue(input string nm, input bit mul, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic e, input logic [31:0] s, output int t);
    ctrl_MULT = mul;
    ctrl_DIV = !mul;
    data_operandA = a;
    data_operandB = b;
    t = cyc + 34;
    sb.push_back('{nm, r, e, s, t});
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = ~a;
    data_operandB = b + 32'd3;
    chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
  endtask
  task automatic wait_done();
    int k = 0;
    while (sb.size() != 0 && k < 80) begin
      @(negedge clock);
      k++;
    end
    if (sb.size() != 0) begin
      chk("timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clock);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask
  initial begin
    int t;
    repeat (3) @(negedge clock);
    chk("rst_result", data_result, 0);
    chk("rst_exception", {31'd0, data_exception}, 0);
    chk("rst_rstatus", rstatus_value, 0);
    chk("rst_rdy", {31'd0, data_resultRDY}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    reset = 1'b1;
    @(negedge clock);
    issue("mul_7x-3", 1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0, 0, t); wait_done();
    issue("mul_ovf", 1, 32'h00010000, 32'h00010000, 32'h0, 1, 4, t); wait_done();
    issue("div_-100/7", 0, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 0, 0, t); wait_done();
    issue("div_by0", 0, 32'd5, 32'd0, 32'd0, 1, 5, t); wait_done();
    issue("div_min/-1", 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 5, t); wait_done();
    issue("mul_min*-1", 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 4, t); wait_done();
    issue("mul_-1*-1", 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 0, 0, t); wait_done();
    issue("div_7/-2", 0, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 0, 0, t); wait_done();
    issue("div_min/1", 0, 32'h80000000, 32'd1, 32'h80000000, 0, 0, t); wait_done();
    issue("mul_3x4_aborted", 1, 32'd3, 32'd4, 32'd12, 0, 0, t);
    repeat (8) @(negedge clock);
    void'(sb.pop_back());
    issue("div_20/4", 0, 32'd20, 32'd4, 32'd5, 0, 0, t); wait_done();
    issue("mul_6x7", 1, 32'd6, 32'd7, 32'd42, 0, 0, t);
    while (cyc < t) @(negedge clock);
    issue("div_b2b", 0, 32'd100, 32'hFFFFFFF6, 32'hFFFFFFF6, 0, 0, t); wait_done();
    issue("mul_reset_aborted", 1, 32'd9, 32'd9, 32'd81, 0, 0, t);
    repeat (14) @(negedge clock);
    reset = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("midrst_result", data_result, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_rstatus", rstatus_value, 0);
    repeat (40) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    issue("mul_2x2", 1, 32'd2, 32'd2, 32'd4, 0, 0, t); wait_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
